// File: rtl/serial_pkg.sv
// Shared definitions for the serial word feeder and the "11" detector side.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SER_WIDTH = 8;

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register with selectable bit order. The register holds the
// word already advanced by one bit, because the first bit leaves via o_first.
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_first,
  output logic             o_tap
);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_load_next;
  logic [WIDTH-1:0] w_shift_next;

  generate
    if (MSB_FIRST) begin : g_msb
      assign o_first      = i_data[WIDTH-1];
      assign o_tap        = r_sreg[WIDTH-1];
      assign w_load_next  = {i_data[WIDTH-2:0], 1'b0};
      assign w_shift_next = {r_sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign o_first      = i_data[0];
      assign o_tap        = r_sreg[0];
      assign w_load_next  = {1'b0, i_data[WIDTH-1:1]};
      assign w_shift_next = {1'b0, r_sreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= w_load_next;
    end else if (i_shift) begin
      r_sreg <= w_shift_next;
    end
  end

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: one word shifting plus one held, so consecutive
// frames go out with no idle cycle between them.
module serial_word_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_load_data;
  logic             w_first;
  logic             w_tap;
  logic [CNT_W-1:0] w_cnt_inc;

  assign din_ready = !r_hold_full && !rst;
  assign w_accept  = din_valid && din_ready;
  assign w_last    = (r_state == SHIFT) && (r_bit_cnt == LAST_CNT);
  assign w_shift   = (r_state == SHIFT) && !w_last;
  assign w_cnt_inc = r_bit_cnt + 1'b1;

  // A full hold buffer always takes priority over a direct load at the frame boundary.
  always_comb begin
    w_load      = 1'b0;
    w_load_data = din;
    if (r_state == IDLE) begin
      w_load = w_accept;
    end else if (w_last) begin
      if (r_hold_full) begin
        w_load      = 1'b1;
        w_load_data = r_hold;
      end else begin
        w_load = w_accept;
      end
    end
  end

  ser_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sreg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_data (w_load_data),
    .o_first(w_first),
    .o_tap  (w_tap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= SHIFT;
            r_bit_cnt    <= '0;
            r_dout       <= w_first;
            r_dout_valid <= 1'b1;
          end else begin
            r_dout       <= IDLE_BIT;
            r_dout_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_last) begin
            if (w_load) begin
              r_bit_cnt    <= '0;
              r_dout       <= w_first;
              r_dout_valid <= 1'b1;
            end else begin
              r_state      <= IDLE;
              r_bit_cnt    <= '0;
              r_dout       <= IDLE_BIT;
              r_dout_valid <= 1'b0;
            end
            if (r_hold_full) begin
              r_hold_full <= w_accept;
              if (w_accept) begin
                r_hold <= din;
              end
            end
          end else begin
            r_bit_cnt    <= w_cnt_inc;
            r_dout       <= w_tap;
            r_frame_done <= (w_cnt_inc == LAST_CNT);
            if (w_accept) begin
              r_hold      <= din;
              r_hold_full <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == SHIFT) || r_hold_full;

endmodule
